// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial ripple-borrow subtractor.
package serial_sub_pkg;

  // Control states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit steps needed to cover a full operand.
  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Width of a counter that indexes digit_count digits (at least one bit).
  function automatic int index_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-bit ripple-borrow slice: {bo, d} = x - y - bi at DIGIT+1 bits.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] full_s;

  // Extend by one bit so the borrow out appears as the MSB of the wrapped result.
  always_comb begin
    full_s = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
    d      = full_s[DIGIT-1:0];
    bo     = full_s[DIGIT];
  end

endmodule

// File: rtl/serial_borrow_sub16.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH/DIGIT cycles,
// with the inter-digit borrow held in a register between cycles.
module serial_borrow_sub16
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = digit_count(WIDTH, DIGIT);
  localparam int IDXW = index_width(NDIG);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  // Operands must split into whole digits.
  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("serial_borrow_sub16: WIDTH must be a multiple of DIGIT");
  end

  state_t             state_r;
  logic [IDXW-1:0]    idx_r;
  logic               borrow_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   diff_r;
  logic               bout_r;
  logic               ovf_r;
  logic               out_valid_r;
  logic               in_ready_r;

  logic [DIGIT-1:0]   x_s;
  logic [DIGIT-1:0]   y_s;
  logic [DIGIT-1:0]   d_s;
  logic               bo_s;
  logic               last_s;
  logic               ovf_s;

  // Select the current digit of each latched operand.
  always_comb begin
    x_s    = a_r[idx_r * DIGIT +: DIGIT];
    y_s    = b_r[idx_r * DIGIT +: DIGIT];
    last_s = (idx_r == LAST_IDX);
    // On the final digit d_s carries the result MSB, so overflow can be
    // formed from it directly without waiting for diff_r to settle.
    ovf_s  = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (d_s[DIGIT-1] ^ a_r[WIDTH-1]);
  end

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_sub_digit (
    .x  (x_s),
    .y  (y_s),
    .bi (borrow_r),
    .d  (d_s),
    .bo (bo_s)
  );

  // Handshake FSM, operand latch, digit stepping and registered result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      borrow_r    <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b;
            borrow_r   <= bin;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
          out_valid_r <= 1'b0;
        end
        RUN: begin
          diff_r[idx_r * DIGIT +: DIGIT] <= d_s;
          borrow_r                       <= bo_s;
          if (last_s) begin
            bout_r      <= bo_s;
            ovf_r       <= ovf_s;
            idx_r       <= '0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        DONE: begin
          // Results stay frozen until the consumer takes them.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          borrow_r    <= 1'b0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;

endmodule
